sprite_pos_ctrl: RTL and testbench

SPRITE_POS_CTRL -- requirements
Module: sprite_pos_ctrl

---
 rtl/sprite_pkg.sv | 56 +++++
 rtl/btn_debounce.sv | 53 +++++
 rtl/sprite_pos_ctrl.sv | 119 +++++++++++
 tb/tb_sprite_pos_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite position path.
// Optional build macro: SPRITE_WRAP_EN (wrap at screen edges instead of clamping).
package sprite_pkg;

  // Screen and sprite geometry shared with the display path
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_W = 16;
  localparam int SPRITE_H = 11;

  // Button indices into the packed button vector
  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTER = 4;
  localparam int BTN_COUNT  = 5;

  typedef logic [11:0] pos_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Next coordinate on one axis: opposing buttons cancel, then the result is
  // clamped (default) or wrapped (SPRITE_WRAP_EN) into [0, max].
  function automatic pos_t axis_next(input pos_t cur, input logic dec, input logic inc,
                                     input pos_t step, input pos_t max);
    logic signed [12:0] sum;
    logic signed [12:0] lim;
    sum = $signed({1'b0, cur});
    lim = $signed({1'b0, max});
    if (dec && !inc) begin
      sum = sum - $signed({1'b0, step});
    end else if (inc && !dec) begin
      sum = sum + $signed({1'b0, step});
    end
`ifdef SPRITE_WRAP_EN
    if (sum < 13'sd0) begin
      sum = sum + lim + 13'sd1;
    end else if (sum > lim) begin
      sum = sum - lim - 13'sd1;
    end
`else
    if (sum < 13'sd0) begin
      sum = 13'sd0;
    end else if (sum > lim) begin
      sum = lim;
    end
`endif
    return pos_t'(sum[11:0]);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stability counter for one push-button.
// The accepted level only flips after DEBOUNCE_CYCLES consecutive samples
// that disagree with it; any agreeing sample restarts the count.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count consecutive disagreeing samples; accept the new level on the last one
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer chain plus debounce state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/sprite_pos_ctrl.sv
// Moves the sprite by STEP pixels per frame from five debounced buttons.
// Position is recomputed once per vertical-sync falling edge and committed
// two clocks later, so the change always lands inside vertical blank.
// Optional build macro: SPRITE_WRAP_EN (wrap at screen edges instead of clamping).
module sprite_pos_ctrl
  import sprite_pkg::*;
#(
  parameter int STEP            = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ROW_MAX         = 469,
  parameter int COL_MAX         = 624,
  parameter int INIT_ROW        = 460,
  parameter int INIT_COL        = 312
) (
  input  logic        vga_clk_i,
  input  logic        vga_rst_n_i,
  input  logic        btn_up_i,
  input  logic        btn_down_i,
  input  logic        btn_left_i,
  input  logic        btn_right_i,
  input  logic        btn_center_i,
  input  logic        vert_sync_i,
  output logic [11:0] btn_row,
  output logic [11:0] btn_col,
  output logic        pos_upd_o
);

  localparam pos_t STEP_P     = pos_t'(STEP);
  localparam pos_t ROW_MAX_P  = pos_t'(ROW_MAX);
  localparam pos_t COL_MAX_P  = pos_t'(COL_MAX);
  localparam pos_t INIT_ROW_P = pos_t'(INIT_ROW);
  localparam pos_t INIT_COL_P = pos_t'(INIT_COL);

  logic [BTN_COUNT-1:0] btn_raw;
  logic [BTN_COUNT-1:0] btn_lvl;

  assign btn_raw[BTN_UP]     = btn_up_i;
  assign btn_raw[BTN_DOWN]   = btn_down_i;
  assign btn_raw[BTN_LEFT]   = btn_left_i;
  assign btn_raw[BTN_RIGHT]  = btn_right_i;
  assign btn_raw[BTN_CENTER] = btn_center_i;

  for (genvar gi = 0; gi < BTN_COUNT; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i  (vga_clk_i),
      .rst_ni (vga_rst_n_i),
      .btn_i  (btn_raw[gi]),
      .level_o(btn_lvl[gi])
    );
  end

  state_e state_q;
  logic   vs_q;
  logic   frame_tick;
  pos_t   row_q;
  pos_t   col_q;
  pos_t   next_row_q;
  pos_t   next_col_q;
  pos_t   row_d;
  pos_t   col_d;
  logic   upd_q;

  // Falling edge of vertical sync against its registered copy
  assign frame_tick = vs_q & ~vert_sync_i;

  // Candidate position from the current debounced buttons; center overrides all
  always_comb begin
    row_d = axis_next(row_q, btn_lvl[BTN_UP], btn_lvl[BTN_DOWN], STEP_P, ROW_MAX_P);
    col_d = axis_next(col_q, btn_lvl[BTN_LEFT], btn_lvl[BTN_RIGHT], STEP_P, COL_MAX_P);
    if (btn_lvl[BTN_CENTER]) begin
      row_d = INIT_ROW_P;
      col_d = INIT_COL_P;
    end
  end

  // Frame FSM: sample buttons in CALC, publish the position in COMMIT
  always_ff @(posedge vga_clk_i or negedge vga_rst_n_i) begin
    if (!vga_rst_n_i) begin
      state_q    <= ST_IDLE;
      vs_q       <= 1'b0;
      row_q      <= INIT_ROW_P;
      col_q      <= INIT_COL_P;
      next_row_q <= INIT_ROW_P;
      next_col_q <= INIT_COL_P;
      upd_q      <= 1'b0;
    end else begin
      vs_q  <= vert_sync_i;
      upd_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_tick) begin
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          next_row_q <= row_d;
          next_col_q <= col_d;
          state_q    <= ST_COMMIT;
        end
        ST_COMMIT: begin
          row_q   <= next_row_q;
          col_q   <= next_col_q;
          upd_q   <= (next_row_q != row_q) || (next_col_q != col_q);
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign btn_row   = row_q;
  assign btn_col   = col_q;
  assign pos_upd_o = upd_q;

endmodule

// File: tb/tb_sprite_pos_ctrl.sv
// Directed and random frames against a frame-level position model.
module tb_sprite_pos_ctrl;

  localparam int STEP     = 2;
  localparam int DEB      = 4;
  localparam int ROW_MAX  = 469;
  localparam int COL_MAX  = 624;
  localparam int INIT_ROW = 460;
  localparam int INIT_COL = 312;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, center = 1'b0;
  logic        vsync = 1'b1;
  logic [11:0] row;
  logic [11:0] col;
  logic        upd;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_row  = INIT_ROW;
  int exp_col  = INIT_COL;
  int frame_no = 0;

  always #5 clk = ~clk;

  sprite_pos_ctrl #(
    .STEP(STEP), .DEBOUNCE_CYCLES(DEB), .ROW_MAX(ROW_MAX), .COL_MAX(COL_MAX),
    .INIT_ROW(INIT_ROW), .INIT_COL(INIT_COL)
  ) dut (
    .vga_clk_i(clk), .vga_rst_n_i(rst_n),
    .btn_up_i(up), .btn_down_i(down), .btn_left_i(left), .btn_right_i(right),
    .btn_center_i(center), .vert_sync_i(vsync),
    .btn_row(row), .btn_col(col), .pos_upd_o(upd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Movement of one coordinate over one frame, from the written rules
  function automatic int move(input int pos, input bit dec, input bit inc, input int max);
    int delta;
    int n;
    delta = (inc ? STEP : 0) - (dec ? STEP : 0);
    n = pos + delta;
`ifdef SPRITE_WRAP_EN
    n = ((n % (max + 1)) + (max + 1)) % (max + 1);
`else
    if (n < 0) n = 0;
    if (n > max) n = max;
`endif
    return n;
  endfunction

  // Hold a button pattern long enough to debounce, issue one frame tick, check timing
  task automatic do_frame(input bit u, input bit d, input bit l, input bit r, input bit c);
    int  new_row;
    int  new_col;
    bit  changed;
    @(negedge clk);
    up = u; down = d; left = l; right = r; center = c;
    repeat (DEB + 6) @(negedge clk);
    if (c) begin
      new_row = INIT_ROW;
      new_col = INIT_COL;
    end else begin
      new_row = move(exp_row, u, d, ROW_MAX);
      new_col = move(exp_col, l, r, COL_MAX);
    end
    changed = (new_row != exp_row) || (new_col != exp_col);
    vsync = 1'b0;
    @(posedge clk);            // tick cycle
    @(posedge clk); #1;        // one clock later: nothing visible yet
    check("row_early", row, exp_row);
    check("upd_early", upd, 0);
    @(posedge clk); #1;        // two clocks later: new position
    check("row", row, new_row);
    check("col", col, new_col);
    check("upd_pulse", upd, changed);
    @(posedge clk); #1;
    check("upd_clear", upd, 0);
    exp_row = new_row;
    exp_col = new_col;
    $display("frame %0d btn u%0d d%0d l%0d r%0d c%0d -> row %0d col %0d upd %0d",
             frame_no, u, d, l, r, c, row, col, changed);
    frame_no++;
    @(negedge clk);
    vsync = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_row", row, INIT_ROW);
    check("rst_col", col, INIT_COL);
    check("rst_upd", upd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_row", row, INIT_ROW);
    check("post_rst_col", col, INIT_COL);

    // Right held across three frames
    repeat (3) do_frame(0, 0, 0, 1, 0);

    // Down to the bottom edge and beyond
    repeat (4) do_frame(0, 1, 0, 0, 0);
    repeat (2) do_frame(0, 1, 0, 0, 0);

    // Up glitch of three clocks is filtered out
    @(negedge clk);
    up = 1'b1;
    repeat (3) @(negedge clk);
    up = 1'b0;
    do_frame(0, 0, 0, 0, 0);
    // Up held long enough is accepted
    do_frame(1, 0, 0, 0, 0);

    // Opposing horizontal buttons cancel, up still applies
    do_frame(1, 0, 1, 1, 0);
    // Center overrides down
    do_frame(0, 1, 0, 0, 1);

    // Random button patterns
    for (int i = 0; i < 24; i++) begin
      bit [3:0] dirs;
      bit       c;
      dirs = 4'($urandom);
      c    = ($urandom_range(0, 7) == 0);
      do_frame(dirs[0], dirs[1], dirs[2], dirs[3], c);
    end

    // Move away from home, then reset right after a tick
    do_frame(0, 0, 0, 1, 0);
    @(negedge clk);
    vsync = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_row", row, INIT_ROW);
    check("abort_col", col, INIT_COL);
    check("abort_upd", upd, 0);
    exp_row = INIT_ROW;
    exp_col = INIT_COL;
    @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("no_late_upd", upd, 0);
      check("no_late_col", col, INIT_COL);
    end
    $display("reset after tick -> row %0d col %0d", row, col);

    // First movement after reset needs a fresh tick
    do_frame(0, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
